ysyx_22040237_ifetch_bridge: RTL and testbench
==============================================

# ysyx_22040237_ifetch_bridge

Instruction-fetch bridge between the single-cycle core's PC output and a valid/ready instruction memory port. It buffers the most recently fetched instruction with its address tag. On a PC hit it supplies the instruction combinationally; on a miss it issues one memory read and stalls the core until the response arrives. It drives the core's instruction input and stall, and supports flush and fetch-fault reporting.

## Interface
Parameters:
- ADDR_W, 32, PC / memory address width
- INST_W, 32, instruction width
- NOP_INST, 32'h0000_0013, instruction presented when no valid instruction is available

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  ADDR_W  current PC from core
- flush  in  1  invalidate buffer, drop any in-flight response
- inst  out  INST_W  instruction to core
- inst_valid  out  1  inst corresponds to current pc
- stall  out  1  = ~inst_valid; core must hold PC/state
- fetch_err  out  1  qualified by inst_valid; fetch faulted
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read address, word-aligned
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  bridge accepts response
- mem_resp_data  in  INST_W  fetched instruction
- mem_resp_err  in  1  bus error on this response

## Operation
- Buffer: buf_valid, buf_tag[ADDR_W], buf_data[INST_W], buf_err.
- hit = buf_valid & (buf_tag == aligned pc); combinational.
- inst_valid = hit; inst = hit ? buf_data : NOP_INST; fetch_err = hit & buf_err.
- FSM states IDLE, REQ, WAIT:
  - IDLE: if ~hit & ~flush, latch req_addr = {pc[ADDR_W-1:2],2'b00}, go REQ.
  - REQ: mem_req_valid=1, mem_req_addr=req_addr. Addr is held stable until handshake. On mem_req_ready, go WAIT. Valid never drops before acceptance, even on flush.
  - WAIT: mem_resp_ready=1. On mem_resp_valid, go IDLE and, unless drop is set, fill buffer with tag=req_addr, data, err.
- drop flag: set by flush in REQ or WAIT; cleared when the response is consumed. A dropped response does not touch the buffer.
- flush in any state clears buf_valid on the next edge.
- PC change during REQ/WAIT: the fetch completes with its own tag. A resulting miss triggers a new fetch from IDLE.
- Only one outstanding request ever.

## Timing
- Reset values: state=IDLE, buf_valid=0, buf_tag=0, buf_data=NOP_INST, buf_err=0, drop=0, mem_req_valid=0, mem_resp_ready=0, inst=NOP_INST, inst_valid=0, stall=1, fetch_err=0.
- Hit latency: 0 cycles (combinational).
- Miss, zero-wait memory: miss seen in IDLE at cycle 0, mem_req_valid at cycle 1, resp accepted at cycle 2, inst_valid=1 at cycle 3.
- Simultaneous mem_resp_valid and flush in WAIT: response consumed and discarded; buffer invalid.
- Simultaneous flush and hit in IDLE: inst_valid stays 1 that cycle and is 0 from the next edge.
- Reset mid-transaction abandons the outstanding request. The memory side must be reset together with the bridge.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: if pc[1:0]!=0, no request is issued. inst_valid=1, fetch_err=1, inst=NOP_INST combinationally. The buffer and FSM are not touched.
- Not defined: pc[1:0] is ignored, and fetch and tag compare use the word-aligned address.

## Structure
- Package ysyx_22040237_ifetch_pkg: FSM state enum (IDLE, REQ, WAIT), NOP_INST constant, address alignment helper function.
- Sub-module ysyx_22040237_ifetch_buf: tag/data/err/valid registers, fill and invalidate ports, hit comparator.
- Top holds the FSM, req_addr, drop and the handshake logic.

## Test plan
- Reset release, pc=0x8000_0000, memory ready=1 and returns 0x0010_0093 one cycle after request: inst_valid rises at cycle 3, inst=0x0010_0093, stall=0 and stays 0 while pc holds.
- Memory holds req_ready=0 for 4 cycles: mem_req_valid and mem_req_addr stay stable the whole time and exactly one request is issued.
- Flush asserted in WAIT, response 0xDEAD_BEEF arrives: buffer stays invalid, stall=1, a new request to the current pc follows.
- Response with mem_resp_err=1 for pc=0x8000_0004: inst_valid=1, fetch_err=1, inst equals the returned data.
- PC changes from 0x8000_0000 to 0x8000_0008 while in WAIT: the first fetch fills with tag 0x8000_0000, then a second request to 0x8000_0008 is issued and completes.
- With IFETCH_MISALIGN_CHECK_EN defined, pc=0x8000_0002: inst_valid=1, fetch_err=1, inst=0x0000_0013, no mem_req_valid.

Source files
------------

// File: rtl/ysyx_22040237_ifetch_pkg.sv
// Shared definitions for the instruction-fetch bridge.
//
// Contents:
//   fetchState_e      - request FSM states (IDLE, REQ, WAIT)
//   DEFAULT_NOP_INST  - instruction shown to the core when nothing valid is buffered
//   isWordAligned()   - returns 1 when the low two PC bits address a word boundary
package ysyx_22040237_ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchState_e;

   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

   function automatic logic isWordAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage

// File: rtl/ysyx_22040237_ifetch_buf.sv
// One-entry instruction buffer holding the most recently fetched word.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   fill_i           - load tag/data/err and mark the entry valid
//   fillTag_i        - word-aligned address of the filled instruction
//   fillData_i       - instruction word
//   fillErr_i        - bus error reported for this word
//   inval_i          - clear the valid bit (wins over fill)
//   lookupAddr_i     - word-aligned address to compare against the tag
//   hit_o            - entry valid and tag matches lookupAddr_i
//   data_o, err_o    - buffered instruction and error flag
module ysyx_22040237_ifetch_buf
   import ysyx_22040237_ifetch_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter int                 INST_W   = 32,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(DEFAULT_NOP_INST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_i,
   input  logic [ADDR_W-1:0] fillTag_i,
   input  logic [INST_W-1:0] fillData_i,
   input  logic              fillErr_i,
   input  logic              inval_i,
   input  logic [ADDR_W-1:0] lookupAddr_i,
   output logic              hit_o,
   output logic [INST_W-1:0] data_o,
   output logic              err_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [INST_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   // Next-state for the entry. Invalidate has priority so a flush that
   // coincides with a fill leaves the entry empty.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      err_d   = err_q;
      if (fill_i) begin
         valid_d = 1'b1;
         tag_d   = fillTag_i;
         data_d  = fillData_i;
         err_d   = fillErr_i;
      end
      if (inval_i) begin
         valid_d = 1'b0;
      end
   end

   // Entry registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= NOP_INST;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign hit_o  = valid_q & (tag_q == lookupAddr_i);
   assign data_o = data_q;
   assign err_o  = err_q;

endmodule

// File: rtl/ysyx_22040237_ifetch_bridge.sv
// Instruction-fetch bridge between the core PC and a valid/ready
// instruction memory. A buffer hit supplies the instruction in the same
// cycle; a miss issues a single memory read and stalls the core until the
// response has been written into the buffer.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   pc                       - current PC from the core
//   flush                    - invalidate buffer, discard in-flight response
//   inst, inst_valid         - instruction to the core and its validity
//   stall                    - inverse of inst_valid
//   fetch_err                - fetch faulted (meaningful with inst_valid)
//   mem_req_valid/ready/addr - read request channel
//   mem_resp_valid/ready     - response handshake
//   mem_resp_data/err        - returned instruction and bus error
//
// Build option: IFETCH_MISALIGN_CHECK_EN - when defined, a PC with nonzero
// low bits reports an immediate fault without touching memory or buffer.
module ysyx_22040237_ifetch_bridge
   import ysyx_22040237_ifetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEFAULT_NOP_INST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic              stall,
   output logic              fetch_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [INST_W-1:0] mem_resp_data,
   input  logic              mem_resp_err
);

   fetchState_e       state_q, state_d;
   logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
   logic              drop_q, drop_d;

   logic [ADDR_W-1:0] pcAligned;
   logic              misaligned;
   logic              bufHit;
   logic [INST_W-1:0] bufData;
   logic              bufErr;
   logic              bufFill;

   assign pcAligned = pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign misaligned = ~isWordAligned(pc[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   // A response fills the buffer only if no flush has occurred since the
   // request was issued, including a flush in the very cycle it arrives.
   assign bufFill = (state_q == WAIT) & mem_resp_valid & ~drop_q & ~flush;

   ysyx_22040237_ifetch_buf #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
   ) u_buf (
      .clk          (clk),
      .rst          (rst),
      .fill_i       (bufFill),
      .fillTag_i    (reqAddr_q),
      .fillData_i   (mem_resp_data),
      .fillErr_i    (mem_resp_err),
      .inval_i      (flush),
      .lookupAddr_i (pcAligned),
      .hit_o        (bufHit),
      .data_o       (bufData),
      .err_o        (bufErr)
   );

   // Request FSM. The request stays valid with a stable address until the
   // memory accepts it, even when flushed; the flush is remembered in drop
   // so the eventual response is consumed and thrown away.
   always_comb begin
      state_d        = state_q;
      reqAddr_d      = reqAddr_q;
      drop_d         = drop_q;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (~bufHit & ~misaligned & ~flush) begin
               reqAddr_d = pcAligned;
               state_d   = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (flush) drop_d = 1'b1;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            mem_resp_ready = 1'b1;
            if (flush) drop_d = 1'b1;
            if (mem_resp_valid) begin
               state_d = IDLE;
               drop_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, request address and drop registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         reqAddr_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         reqAddr_q <= reqAddr_d;
         drop_q    <= drop_d;
      end
   end

   assign mem_req_addr = reqAddr_q;

   // Core-facing outputs. A misaligned PC (when checked) overrides the
   // buffer with an immediate faulting NOP.
   assign inst_valid = misaligned | bufHit;
   assign inst       = (bufHit & ~misaligned) ? bufData : NOP_INST;
   assign fetch_err  = misaligned | (bufHit & bufErr);
   assign stall      = ~inst_valid;

endmodule

// File: tb/tb_ysyx_22040237_ifetch_bridge.sv
// Self-checking bench for ysyx_22040237_ifetch_bridge: directed scenarios
// followed by randomized traffic, all compared against a transaction-level
// reference model of the buffer and the single outstanding fetch.
module tb_ysyx_22040237_ifetch_bridge;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] P0  = 32'h8000_0000;
   localparam logic [31:0] P1  = 32'h8000_0010;
   localparam logic [31:0] P2  = 32'h8000_0020;
   localparam logic [31:0] P3  = 32'h8000_0008;
   localparam logic [31:0] P4  = 32'h8000_0004;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        stall;
   logic        fetch_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;

   int errors = 0;
   int checks = 0;

   // Reference model: buffer contents plus the one fetch in flight.
   // txnPhase: 0 = none, 1 = request offered, 2 = accepted, awaiting data.
   bit          mValid;
   logic [31:0] mTag;
   logic [31:0] mData;
   bit          mErr;
   int          txnPhase;
   logic [31:0] txnAddr;
   bit          txnDropped;

   // Values observed in the most recent cycle.
   logic        obsValid, obsStall, obsErr, obsReqValid, obsRespReady;
   logic [31:0] obsInst, obsReqAddr;

   ysyx_22040237_ifetch_bridge dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .flush          (flush),
      .inst           (inst),
      .inst_valid     (inst_valid),
      .stall          (stall),
      .fetch_err      (fetch_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mValid     = 1'b0;
      mTag       = '0;
      mData      = NOP;
      mErr       = 1'b0;
      txnPhase   = 0;
      txnAddr    = '0;
      txnDropped = 1'b0;
   endtask

   task automatic applyReset();
      rst            = 1'b1;
      pc             = P0;
      flush          = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_inst",      inst,           NOP);
      checkOutput("rst_valid",     inst_valid,     32'd0);
      checkOutput("rst_stall",     stall,          32'd1);
      checkOutput("rst_ferr",      fetch_err,      32'd0);
      checkOutput("rst_reqValid",  mem_req_valid,  32'd0);
      checkOutput("rst_respReady", mem_resp_ready, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Drive one cycle of inputs, compare outputs against the model in the
   // middle of the cycle, then advance the model by the handshakes that
   // will complete at the next rising edge.
   task automatic applyStimulus(input logic [31:0] pcV, input bit flushV, input bit reqReadyV,
                                input bit respValidV, input logic [31:0] dataV, input bit errV);
      logic [31:0] aligned;
      bit          misal, expHit, expValid;
      logic [31:0] expInst;
      bit          expErr;
      pc             = pcV;
      flush          = flushV;
      mem_req_ready  = reqReadyV;
      mem_resp_valid = respValidV;
      mem_resp_data  = dataV;
      mem_resp_err   = errV;
      @(negedge clk);
      obsValid     = inst_valid;
      obsStall     = stall;
      obsErr       = fetch_err;
      obsInst      = inst;
      obsReqValid  = mem_req_valid;
      obsRespReady = mem_resp_ready;
      obsReqAddr   = mem_req_addr;

      aligned = {pcV[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
      misal = (pcV[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      expHit   = mValid && (mTag == aligned);
      expValid = misal || expHit;
      expInst  = (expHit && !misal) ? mData : NOP;
      expErr   = misal || (expHit && mErr);

      checkOutput("inst_valid",     obsValid,     {31'd0, expValid});
      checkOutput("inst",           obsInst,      expInst);
      checkOutput("stall",          obsStall,     {31'd0, !expValid});
      checkOutput("fetch_err",      obsErr,       {31'd0, expErr});
      checkOutput("mem_req_valid",  obsReqValid,  {31'd0, txnPhase == 1});
      checkOutput("mem_resp_ready", obsRespReady, {31'd0, txnPhase == 2});
      if (txnPhase == 1) checkOutput("mem_req_addr", obsReqAddr, txnAddr);

      case (txnPhase)
         0: if (!expValid && !flushV) begin
               txnPhase   = 1;
               txnAddr    = aligned;
               txnDropped = 1'b0;
            end
         1: begin
               if (flushV) txnDropped = 1'b1;
               if (reqReadyV) txnPhase = 2;
            end
         2: begin
               if (flushV) txnDropped = 1'b1;
               if (respValidV) begin
                  if (!txnDropped) begin
                     mValid = 1'b1;
                     mTag   = txnAddr;
                     mData  = dataV;
                     mErr   = errV;
                  end
                  txnPhase   = 0;
                  txnDropped = 1'b0;
               end
            end
         default: txnPhase = 0;
      endcase
      if (flushV) mValid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Run a well-behaved memory until pcV hits in an idle bridge.
   task automatic settle(input logic [31:0] pcV);
      bit done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (txnPhase == 0 && mValid && mTag == {pcV[31:2], 2'b00}) begin
            done = 1'b1;
            break;
         end
         applyStimulus(pcV, 1'b0, 1'b1, txnPhase == 2, $urandom, 1'b0);
      end
      checkOutput("settle_timeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int reqCount;
      logic [31:0] curPc;
      applyReset();

      // Zero-wait miss: valid exactly at cycle 3, then held while pc stays.
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      checkOutput("t1_c0_reqValid", obsReqValid, 32'd0);
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      checkOutput("t1_c1_reqValid", obsReqValid, 32'd1);
      checkOutput("t1_c1_reqAddr", obsReqAddr, P0);
      applyStimulus(P0, 0, 1, 1, 32'h0010_0093, 0);
      checkOutput("t1_c2_valid", obsValid, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(P0, 0, 1, 0, 32'h0, 0);
         checkOutput("t1_hold_valid", obsValid, 32'd1);
         checkOutput("t1_hold_inst", obsInst, 32'h0010_0093);
         checkOutput("t1_hold_stall", obsStall, 32'd0);
      end

      // Flush coinciding with a hit: valid this cycle, gone next cycle.
      applyStimulus(P0, 1, 1, 0, 32'h0, 0);
      checkOutput("fh_same_valid", obsValid, 32'd1);
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      checkOutput("fh_next_valid", obsValid, 32'd0);
      settle(P0);

      // Memory stalls the request for 4 cycles: one stable request.
      reqCount = 0;
      applyStimulus(P1, 0, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(P1, 0, 0, 0, 32'h0, 0);
         checkOutput("t2_wait_reqValid", obsReqValid, 32'd1);
         checkOutput("t2_wait_reqAddr", obsReqAddr, P1);
      end
      applyStimulus(P1, 0, 1, 0, 32'h0, 0);
      if (obsReqValid) reqCount++;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(P1, 0, 1, i == 0, 32'hAAAA_0001, 0);
         if (obsReqValid) reqCount++;
      end
      checkOutput("t2_reqCount", reqCount, 32'd1);
      checkOutput("t2_inst", obsInst, 32'hAAAA_0001);

      // Flush while waiting: response discarded, then refetched.
      applyStimulus(P2, 0, 1, 0, 32'h0, 0);
      applyStimulus(P2, 0, 1, 0, 32'h0, 0);
      applyStimulus(P2, 1, 1, 0, 32'h0, 0);
      applyStimulus(P2, 0, 1, 1, 32'hDEAD_BEEF, 0);
      applyStimulus(P2, 0, 1, 0, 32'h0, 0);
      checkOutput("t3_valid", obsValid, 32'd0);
      checkOutput("t3_stall", obsStall, 32'd1);
      applyStimulus(P2, 0, 1, 0, 32'h0, 0);
      checkOutput("t3_refetchValid", obsReqValid, 32'd1);
      checkOutput("t3_refetchAddr", obsReqAddr, P2);
      settle(P2);

      // Faulting response still delivers its data.
      applyStimulus(P4, 0, 1, 0, 32'h0, 0);
      applyStimulus(P4, 0, 1, 0, 32'h0, 0);
      applyStimulus(P4, 0, 1, 1, 32'h1234_5678, 1);
      applyStimulus(P4, 0, 1, 0, 32'h0, 0);
      checkOutput("t4_valid", obsValid, 32'd1);
      checkOutput("t4_ferr", obsErr, 32'd1);
      checkOutput("t4_inst", obsInst, 32'h1234_5678);

      // PC moves while waiting: old fetch fills under its own tag.
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      applyStimulus(P3, 0, 1, 0, 32'h0, 0);
      applyStimulus(P3, 0, 1, 1, 32'h5555_0000, 0);
      applyStimulus(P0, 0, 1, 0, 32'h0, 0);
      checkOutput("t5_oldTagHit", obsInst, 32'h5555_0000);
      applyStimulus(P3, 0, 1, 0, 32'h0, 0);
      checkOutput("t5_miss", obsValid, 32'd0);
      applyStimulus(P3, 0, 1, 0, 32'h0, 0);
      checkOutput("t5_req2Addr", obsReqAddr, P3);
      applyStimulus(P3, 0, 1, 1, 32'h6666_0000, 0);
      applyStimulus(P3, 0, 1, 0, 32'h0, 0);
      checkOutput("t5_inst2", obsInst, 32'h6666_0000);

      // Randomized traffic over a small address window.
      curPc = P0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) applyReset();
         if ($urandom_range(0, 9) < 3)
            curPc = 32'h8000_0000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
         applyStimulus(curPc,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) != 0,
                       (txnPhase == 2) && ($urandom_range(0, 2) != 0),
                       $urandom,
                       $urandom_range(0, 7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
